// File: rtl/dp_timing_tx.sv
// dp_timing_tx: 1920x1080-style video timing transmitter.
//
// Produces the 27-bit bus {vsync, hsync, den, R, G, B}. Active pixels are
// pulled from an upstream ready/valid source. The timing never stalls: when
// the source has nothing during an active pixel, FILL_RGB is sent instead
// and a sticky underflow flag is raised.
//
// Ports:
//   clk           clock
//   rst_n         asynchronous active-low reset
//   en            run request; dropping it finishes the current frame first
//   pix_valid     upstream pixel valid
//   pix_data      upstream pixel {R,G,B}
//   pix_ready     block accepts pix_data this cycle (combinational)
//   dp_out        [26] vsync, [25] hsync, [24] den, [23:0] RGB (registered)
//   frame_start   one-clock pulse aligned with pixel (0,0) on dp_out
//   underflow     sticky underflow flag
//   underflow_clr clears underflow (a same-clock set wins)
//   busy          high while the block is not idle (aligned with dp_out)
//
// Optional build macro DP_TIMING_TX_PATTERN_EN adds input pattern_sel[1:0]:
//   0 upstream data, 1 four vertical colour bars, 2 horizontal ramp,
//   3 solid FILL_RGB. The selection is latched at the start of each frame.

module dp_timing_tx #(
  parameter int          H_ACTIVE = 1920,
  parameter int          H_FP     = 88,
  parameter int          H_SYNC   = 44,
  parameter int          H_BP     = 148,
  parameter int          V_ACTIVE = 1080,
  parameter int          V_FP     = 4,
  parameter int          V_SYNC   = 5,
  parameter int          V_BP     = 36,
  parameter logic [23:0] FILL_RGB = 24'h000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        pix_valid,
  input  logic [23:0] pix_data,
  output logic        pix_ready,
  output logic [26:0] dp_out,
  output logic        frame_start,
  output logic        underflow,
  input  logic        underflow_clr,
  output logic        busy
`ifdef DP_TIMING_TX_PATTERN_EN
  ,
  input  logic [1:0]  pattern_sel
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
  localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VS_START = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [11:0] h_cnt, v_cnt;
  logic        active, frame_end, den, hsync, vsync;
  logic        use_src, uf_set;
  logic [23:0] rgb_next;

  assign active    = (state != IDLE);
  assign frame_end = (h_cnt == H_LAST) && (v_cnt == V_LAST);
  assign den       = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hsync     = (h_cnt >= HS_START) && (h_cnt < HS_END);
  assign vsync     = (v_cnt >= VS_START) && (v_cnt < VS_END);

`ifdef DP_TIMING_TX_PATTERN_EN
  localparam logic [11:0] BAR1 = 12'(H_ACTIVE / 4);
  localparam logic [11:0] BAR2 = 12'(2 * (H_ACTIVE / 4));
  localparam logic [11:0] BAR3 = 12'(3 * (H_ACTIVE / 4));

  logic [1:0]  pat_q, pat_eff;
  logic [23:0] pat_rgb;

  // The live select is only honoured at (0,0); the rest of the frame uses
  // the copy latched there, so a frame never mixes two patterns.
  assign pat_eff = ((h_cnt == 12'd0) && (v_cnt == 12'd0)) ? pattern_sel : pat_q;
  assign use_src = (pat_eff == 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pat_q <= 2'd0;
    else        pat_q <= pat_eff;
  end

  always_comb begin
    pat_rgb = FILL_RGB;
    case (pat_eff)
      2'd1: begin
        if      (h_cnt < BAR1) pat_rgb = 24'hFF0000;
        else if (h_cnt < BAR2) pat_rgb = 24'h00FF00;
        else if (h_cnt < BAR3) pat_rgb = 24'h0000FF;
        else                   pat_rgb = 24'hFFFFFF;
      end
      2'd2:    pat_rgb = {3{h_cnt[10:3]}};
      default: pat_rgb = FILL_RGB;
    endcase
  end
`else
  logic [23:0] pat_rgb;
  assign use_src = 1'b1;
  assign pat_rgb = FILL_RGB;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Stopping is deferred to the last clock of a frame. When en drops on that
  // very clock the frame is already complete, so we go straight to IDLE
  // rather than draining a whole extra frame.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (en) state_next = RUN;
      RUN:     if (!en) state_next = frame_end ? IDLE : DRAIN;
      DRAIN: begin
        if (en)             state_next = RUN;
        else if (frame_end) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    pix_ready = active && den && use_src;
    uf_set    = active && den && use_src && !pix_valid;
    rgb_next  = 24'h000000;
    if (den) begin
      if (!use_src)       rgb_next = pat_rgb;
      else if (pix_valid) rgb_next = pix_data;
      else                rgb_next = FILL_RGB;
    end
  end

  // Counters sit at (0,0) while idle so a restart always begins a fresh frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= 12'd0;
      v_cnt <= 12'd0;
    end else if (!active) begin
      h_cnt <= 12'd0;
      v_cnt <= 12'd0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= 12'd0;
      v_cnt <= (v_cnt == V_LAST) ? 12'd0 : v_cnt + 12'd1;
    end else begin
      h_cnt <= h_cnt + 12'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_out      <= 27'd0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      dp_out      <= active ? {vsync, hsync, den, rgb_next} : 27'd0;
      frame_start <= active && (h_cnt == 12'd0) && (v_cnt == 12'd0);
      busy        <= active;
      underflow   <= uf_set || (underflow && !underflow_clr);
    end
  end

endmodule

// File: tb/tb_dp_timing_tx.sv
// Self-checking bench for dp_timing_tx, using a reduced raster so several
// whole frames fit in a short run.

module tb_dp_timing_tx;

  localparam int HA = 16, HFP = 3, HS = 4, HBP = 5;
  localparam int VA = 6,  VFP = 1, VS = 2, VBP = 2;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int NF = HT * VT;
  localparam logic [23:0] FILL = 24'h00A5C3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        pix_valid = 1'b0;
  logic [23:0] pix_data = 24'h0;
  logic        pix_ready;
  logic [26:0] dp_out;
  logic        frame_start;
  logic        underflow;
  logic        underflow_clr = 1'b0;
  logic        busy;
`ifdef DP_TIMING_TX_PATTERN_EN
  logic [1:0]  pattern_sel = 2'd0;
`endif

  dp_timing_tx #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .FILL_RGB(FILL)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .pix_valid(pix_valid),
    .pix_data(pix_data),
    .pix_ready(pix_ready),
    .dp_out(dp_out),
    .frame_start(frame_start),
    .underflow(underflow),
    .underflow_clr(underflow_clr),
    .busy(busy)
`ifdef DP_TIMING_TX_PATTERN_EN
    ,
    .pattern_sel(pattern_sel)
`endif
  );

  always #5 clk = ~clk;

  int nVectors = 0;
  int nMiscompares = 0;

  // Reference model: raster position of the clock about to be processed,
  // whether the transmitter is running, and the expected registered outputs.
  int          mh = 0, mv = 0;
  bit          mActive = 0;
  bit          modelOn = 1;
  bit          lastXfer = 0;
  logic [26:0] expDp = '0;
  logic        expFs = 0, expBusy = 0, expUf = 0;

  // Frame statistics gathered from the output bus.
  int monCyc = 0, lastFsCyc = 0, lastSpacing = 0, denCnt = 0, lastFrameDen = 0;
  bit seenFs = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      seenFs = 0;
      denCnt = 0;
    end else begin
      monCyc++;
      if (frame_start) begin
        if (seenFs) begin
          lastSpacing  = monCyc - lastFsCyc;
          lastFrameDen = denCnt;
        end
        seenFs    = 1;
        lastFsCyc = monCyc;
        denCnt    = 0;
      end
      if (dp_out[24]) denCnt++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVectors++;
    assert (obs === exp) else begin
      nMiscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelStep(input logic e, input logic v, input logic [23:0] d, input logic c);
    bit inPix, hs, vs, atEnd;
    inPix = (mh < HA) && (mv < VA);
    hs    = (mh >= HA + HFP) && (mh < HA + HFP + HS);
    vs    = (mv >= VA + VFP) && (mv < VA + VFP + VS);
    checkOutput("pix_ready", 32'(pix_ready), 32'(mActive && inPix));
    lastXfer = mActive && inPix && v;
    if (mActive) expDp = {vs, hs, inPix, inPix ? (v ? d : FILL) : 24'h0};
    else         expDp = '0;
    expFs   = mActive && (mh == 0) && (mv == 0);
    expBusy = mActive;
    if (mActive && inPix && !v) expUf = 1'b1;
    else if (c)                 expUf = 1'b0;
    atEnd = (mh == HT - 1) && (mv == VT - 1);
    if (mActive) begin
      mh++;
      if (mh == HT) begin
        mh = 0;
        mv = (mv + 1) % VT;
      end
    end else begin
      mh = 0;
      mv = 0;
    end
    // A run request is only acted on from idle or at a frame boundary.
    if (!mActive || atEnd) mActive = e;
  endtask

  task automatic applyStimulus(input logic e, input logic v, input logic [23:0] d, input logic c);
    @(negedge clk);
    if (modelOn) begin
      checkOutput("dp_out", 32'(dp_out), 32'(expDp));
      checkOutput("frame_start", 32'(frame_start), 32'(expFs));
      checkOutput("busy", 32'(busy), 32'(expBusy));
      checkOutput("underflow", 32'(underflow), 32'(expUf));
    end
    en = e;
    pix_valid = v;
    pix_data = d;
    underflow_clr = c;
    #1;
    if (modelOn) modelStep(e, v, d, c);
  endtask

  task automatic doReset(input int cycles);
    @(negedge clk);
    en = 0;
    pix_valid = 0;
    underflow_clr = 0;
    rst_n = 0;
    #1;
    checkOutput("rst_dp_out", 32'(dp_out), 32'h0);
    checkOutput("rst_frame_start", 32'(frame_start), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_underflow", 32'(underflow), 32'h0);
    checkOutput("rst_pix_ready", 32'(pix_ready), 32'h0);
    repeat (cycles) @(negedge clk);
    checkOutput("rst_hold_dp_out", 32'(dp_out), 32'h0);
    checkOutput("rst_hold_busy", 32'(busy), 32'h0);
    rst_n = 1;
    mh = 0; mv = 0; mActive = 0;
    expDp = '0; expFs = 0; expBusy = 0; expUf = 0;
  endtask

  // Raise en from idle; pixel (0,0) must appear two clocks later.
  task automatic startFrame(input logic [23:0] d0);
    applyStimulus(1, 1, d0, 0);
    applyStimulus(1, 1, d0, 0);
    @(posedge clk);
    #1;
    checkOutput("start_den", 32'(dp_out[24]), 32'h1);
    checkOutput("start_frame_start", 32'(frame_start), 32'h1);
    checkOutput("start_rgb", 32'(dp_out[23:0]), 32'(d0));
  endtask

  task automatic seekTo(input int h, input int v, input string tag);
    int guard = 0;
    while (!(mh == h && mv == v) && guard < 2 * NF) begin
      applyStimulus(1, 1, 24'($urandom), 0);
      guard++;
    end
    checkOutput(tag, 32'(guard < 2 * NF), 32'h1);
  endtask

  initial begin
    int pixCnt;
    int idx;
    int k;

    // Reset, then a frame with a constant-valid counting source.
    doReset(3);
    startFrame(24'h000000);
    pixCnt = 1;
    repeat (2 * NF) begin
      applyStimulus(1, 1, 24'(pixCnt), 0);
      if (lastXfer) pixCnt++;
    end
    checkOutput("frame_den_count", 32'(lastFrameDen), 32'(HA * VA));
    checkOutput("frame_spacing", 32'(lastSpacing), 32'(NF));

    // Three-pixel underflow at (5,0), then clear and set-wins-over-clear.
    seekTo(5, 0, "seek_underflow");
    repeat (3) applyStimulus(1, 0, 24'($urandom), 0);
    applyStimulus(1, 1, 24'($urandom), 0);
    applyStimulus(1, 1, 24'($urandom), 0);
    checkOutput("underflow_sticky", 32'(underflow), 32'h1);
    applyStimulus(1, 1, 24'($urandom), 1);
    applyStimulus(1, 1, 24'($urandom), 0);
    checkOutput("underflow_cleared", 32'(underflow), 32'h0);
    applyStimulus(1, 0, 24'($urandom), 1);
    applyStimulus(1, 1, 24'($urandom), 0);
    checkOutput("underflow_set_wins", 32'(underflow), 32'h1);
    applyStimulus(1, 1, 24'($urandom), 1);

    // Random source behaviour over two frames.
    repeat (2 * NF)
      applyStimulus(1, ($urandom_range(0, 7) != 0), 24'($urandom), ($urandom_range(0, 15) == 0));

    // Drop en mid-frame: the frame finishes, then the bus goes quiet.
    seekTo(10, 3, "seek_drain");
    idx = mv * HT + mh;
    k = 0;
    do begin
      applyStimulus(0, ($urandom_range(0, 3) != 0), 24'($urandom), 0);
      k++;
    end while (busy && k < NF + 5);
    checkOutput("drain_length", 32'(k), 32'(NF - idx + 2));
    checkOutput("drain_dp_out", 32'(dp_out), 32'h0);
    checkOutput("drain_pix_ready", 32'(pix_ready), 32'h0);
    repeat (5) applyStimulus(0, 1, 24'($urandom), 0);

    // en 1->0->1 inside a frame must not disturb frame_start spacing.
    startFrame(24'($urandom));
    repeat (NF + 40) applyStimulus(1, ($urandom_range(0, 7) != 0), 24'($urandom), 0);
    repeat (30)      applyStimulus(0, ($urandom_range(0, 7) != 0), 24'($urandom), 0);
    lastSpacing = 0;
    repeat (NF - 20) applyStimulus(1, ($urandom_range(0, 7) != 0), 24'($urandom), 0);
    checkOutput("toggle_spacing", 32'(lastSpacing), 32'(NF));

    // Asynchronous reset mid-frame, then a fresh full-length frame.
    seekTo(7, 3, "seek_reset");
    doReset(2);
    lastSpacing = 0;
    lastFrameDen = 0;
    startFrame(24'($urandom));
    repeat (NF + 10) applyStimulus(1, ($urandom_range(0, 7) != 0), 24'($urandom), 0);
    checkOutput("post_reset_den_count", 32'(lastFrameDen), 32'(HA * VA));
    checkOutput("post_reset_spacing", 32'(lastSpacing), 32'(NF));

`ifdef DP_TIMING_TX_PATTERN_EN
    // Colour bars: upstream is ignored and underflow never sets.
    begin
      logic [23:0] bars [4];
      bars[0] = 24'hFF0000; bars[1] = 24'h00FF00; bars[2] = 24'h0000FF; bars[3] = 24'hFFFFFF;
      doReset(2);
      modelOn = 0;
      pattern_sel = 2'd1;
      applyStimulus(1, 0, 24'h123456, 0);
      applyStimulus(1, 0, 24'h123456, 0);
      for (int p = 0; p < HA; p++) begin
        @(posedge clk);
        #1;
        checkOutput("pattern_pix_ready", 32'(pix_ready), 32'h0);
        if (p == 0 || p == HA / 4 || p == HA / 2 || p == HA - 1)
          checkOutput("pattern_bar_rgb", 32'(dp_out[23:0]), 32'(bars[p / (HA / 4)]));
      end
      checkOutput("pattern_no_underflow", 32'(underflow), 32'h0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule

// File: doc/dp_timing_tx.md
Name: dp_timing_tx

Overview:
- Video transmitter that generates the 27-bit display-port-style bus {vsync, hsync, den, R[7:0], G[7:0], B[7:0]} consumed by the pixel processing pipeline.
- Produces 1920x1080 timing, pulls active pixels from an upstream ready/valid source, and inserts a fill colour on source underflow.
- Sits at the head of the video chain. Used as the bench stimulus source and as the on-chip frame source.

Parameters:
- H_ACTIVE, 1920, active pixels per line
- H_FP, 88, horizontal front porch clocks
- H_SYNC, 44, hsync width clocks
- H_BP, 148, horizontal back porch clocks
- V_ACTIVE, 1080, active lines per frame
- V_FP, 4, vertical front porch lines
- V_SYNC, 5, vsync width lines
- V_BP, 36, vertical back porch lines
- FILL_RGB, 24'h000000, colour emitted on underflow

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- en  input  1  run request
- pix_valid  input  1  upstream pixel valid
- pix_data  input  24  upstream pixel {R,G,B}
- pix_ready  output  1  block accepts pix_data this cycle
- dp_out  output  27  bus: [26] vsync, [25] hsync, [24] den, [23:0] RGB
- frame_start  output  1  one-clock pulse aligned with pixel (0,0) on dp_out
- underflow  output  1  sticky underflow flag
- underflow_clr  input  1  clears underflow
- busy  output  1  high while not IDLE

Behaviour:
- Reset values: dp_out=0, frame_start=0, underflow=0, busy=0, pix_ready=0, h/v counters=0, state=IDLE.
- Line order: active, front porch, sync, back porch. Frame order uses the same sequence in lines. H_TOTAL=2200, V_TOTAL=1125.
- h_cnt wraps at H_TOTAL-1 to 0. v_cnt increments on that wrap and itself wraps at V_TOTAL-1 to 0. Both counters are 12 bits.
- Region decode:
  - den = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE.
  - hsync = h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vsync = v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC), held for whole lines.
  - Both syncs are active-high.
- State machine has three states: IDLE, RUN, DRAIN.
  - IDLE: counters held at 0, dp_out=0, pix_ready=0. en=1 moves to RUN next clock, starting at (0,0).
  - RUN: counters advance every clock. en=0 moves to DRAIN.
  - DRAIN: continues advancing. At the (H_TOTAL-1, V_TOTAL-1) clock it moves to IDLE, so a frame is never truncated. en=1 while in DRAIN returns to RUN with no disturbance to timing.
- pix_ready is combinational: (state!=IDLE) && den(current counters).
  - A transfer occurs when pix_ready && pix_valid.
  - pix_data is accepted only on transfer. The source must hold data while valid && !ready.
- Output registered, latency 1 clock. dp_out at cycle t+1 reflects the counter position and data at cycle t.
  - RGB = pix_data on transfer.
  - RGB = FILL_RGB when den && !pix_valid (underflow).
  - RGB = 0 when den=0.
- Underflow:
  - Timing never stalls on underflow.
  - underflow sets the cycle after a den && !pix_valid clock and stays set until underflow_clr.
  - If set and clear occur in the same clock, set wins.
- frame_start=1 for exactly the one clock where dp_out carries den=1 for pixel (0,0).
- busy = state!=IDLE, registered.
- Asynchronous reset mid-frame returns everything to the reset values immediately. The next en starts a fresh frame at (0,0).
- The pipeline's position counter counts den pixels and clears on vsync. This block guarantees exactly H_ACTIVE*V_ACTIVE den clocks between vsync pulses.

Optional Feature:
- Macro: DP_TIMING_TX_PATTERN_EN.
- When defined, an input pattern_sel [1:0] is added:
  - 0: upstream data (normal operation).
  - 1: four vertical bars of 480 pixels each: red FF0000, green 00FF00, blue 0000FF, white FFFFFF.
  - 2: horizontal ramp, RGB = {3{h_cnt[10:3]}}.
  - 3: solid FILL_RGB.
- For pattern_sel!=0: pix_ready=0, underflow never sets, and pattern_sel is sampled only at frame start.
- When undefined, the port is absent and behaviour is always upstream data.

Test Plan:
- Reset, en=1, pix_valid=1 constant, pix_data=counter:
  - first dp_out den=1 appears 2 clocks after en rises (1 clock IDLE->RUN, 1 clock output register), with frame_start=1 and RGB=000000;
  - 1920 den clocks per line and 1080 lines per frame;
  - hsync high at h 2008..2051;
  - vsync high for lines 1084..1088;
  - total 2,475,000 clocks per frame.
- pix_valid=0 at pixel (5,0) for 3 clocks:
  - dp_out RGB=FILL_RGB for those 3 pixels and timing is unchanged;
  - underflow=1 and stays 1;
  - pulsing underflow_clr clears it;
  - clear and set in the same clock leaves underflow=1.
- en=0 at mid-frame (h=100, v=500):
  - busy stays 1 until the end of line 1124;
  - then dp_out=0 and pix_ready=0;
  - no partial frame is emitted.
- en toggles 1->0->1 within one frame: no discontinuity in h/v and frame_start spacing stays 2,475,000 clocks.
- rst_n low for 2 clocks at (700,300), then en=1:
  - all outputs are 0 during reset;
  - the next frame_start comes 2 clocks after en rises (same as from IDLE) and the frame is full-length.
- With DP_TIMING_TX_PATTERN_EN and pattern_sel=1:
  - pixel 0 = FF0000, pixel 480 = 00FF00, pixel 960 = 0000FF, pixel 1919 = FFFFFF;
  - pix_ready stays 0.
